// File: rtl/master_out_port_if.sv
// master_out_port_if: serial request lines between the master transmit port and the slave input port.
interface master_out_port_if;
   logic master_valid, slave_ready, tx_address, tx_data, write_en, read_en, tx_burst;
   modport master(output master_valid, tx_address, tx_data, write_en, read_en, tx_burst, input slave_ready);
   modport slave(input master_valid, tx_address, tx_data, write_en, read_en, tx_burst, output slave_ready);
endinterface

// File: rtl/master_out_port.sv
// master_out_port: serialises one address/data request LSB-first under master_valid/slave_ready.
// Define MASTER_TIMEOUT_EN to abandon REQ after TIMEOUT cycles with a one-cycle tx_error pulse.
module master_out_port #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] data_in,
   master_out_port_if.master bus,
   output logic              busy,
   output logic              tx_done,
   output logic              tx_error
);
   localparam int CW = $clog2(ADDR_W);
   typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;
   state_t state_q;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] d_q;
   logic [CW-1:0] cnt_q;
   logic mv_q, ta_q, td_q, we_q, re_q, busy_q, done_q;
`ifdef MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0] to_q;
   logic err_q;
   assign tx_error = err_q;
`else
   assign tx_error = 1'b0;
`endif
   assign bus.master_valid = mv_q;
   assign bus.tx_address = ta_q;
   assign bus.tx_data = td_q;
   assign bus.write_en = we_q;
   assign bus.read_en = re_q;
   assign bus.tx_burst = 1'b0;
   assign busy = busy_q;
   assign tx_done = done_q;
   // Shift registers hold the bits still to be presented; the output flops carry the current bit.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         a_q <= '0;
         d_q <= '0;
         cnt_q <= '0;
         {mv_q, ta_q, td_q, we_q, re_q, busy_q, done_q} <= '0;
`ifdef MASTER_TIMEOUT_EN
         to_q <= '0;
         err_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef MASTER_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         case (state_q)
            IDLE, DONE:
               if (start) begin
                  state_q <= REQ;
                  mv_q <= 1'b1;
                  busy_q <= 1'b1;
                  we_q <= rw;
                  re_q <= !rw;
                  ta_q <= addr_in[0];
                  td_q <= rw & data_in[0];
                  a_q <= addr_in >> 1;
                  d_q <= rw ? data_in >> 1 : '0;
`ifdef MASTER_TIMEOUT_EN
                  to_q <= '0;
`endif
               end else state_q <= IDLE;
            REQ:
               if (mv_q && bus.slave_ready) begin
                  state_q <= SEND;
                  mv_q <= 1'b0;
                  ta_q <= a_q[0];
                  td_q <= d_q[0];
                  a_q <= a_q >> 1;
                  d_q <= d_q >> 1;
                  cnt_q <= CW'(1);
               end
`ifdef MASTER_TIMEOUT_EN
               // Last REQ cycle is TIMEOUT-1; the error becomes visible on the cycle after it.
               else if (to_q == TW'(TIMEOUT - 2)) begin
                  state_q <= IDLE;
                  {mv_q, ta_q, td_q, we_q, re_q, busy_q} <= '0;
                  err_q <= 1'b1;
               end else to_q <= to_q + 1'b1;
`endif
            SEND:
               if (cnt_q == CW'(ADDR_W - 1)) begin
                  state_q <= DONE;
                  {ta_q, td_q, we_q, re_q, busy_q} <= '0;
                  done_q <= 1'b1;
               end else begin
                  ta_q <= a_q[0];
                  td_q <= d_q[0];
                  a_q <= a_q >> 1;
                  d_q <= d_q >> 1;
                  cnt_q <= cnt_q + 1'b1;
               end
         endcase
      end
endmodule
